ss_addsub_seq: RTL and testbench

Sequencer for one stochastic add/subtract evaluation window around an `SS_ADDSUB_CARRY` instance.
- Holds the adder in INIT while idle, then runs the upstream stochastic number generators for exactly `LEN` clocks.
- Alternates the adder's `R_condition` tie-break every cycle and integrates the signed output bitstream (`OUT`, `SIGN_out`) into a two's-complement count.
- Presents that count to the neuron-layer controller through a valid/ack handshake.

---
 rtl/ss_addsub_seq.sv | 146 ++++++++++++++
 tb/tb_ss_addsub_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_addsub_seq.sv
// ss_addsub_seq: sequences one stochastic add/subtract evaluation window.
// Holds the adder in INIT while idle, runs the SNGs for LEN clocks, toggles
// the adder tie-break each RUN cycle and integrates the signed output stream
// into a two's-complement count that is handed off via valid/ack.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | adder held in INIT, waiting for START
// CLR   | one cycle: clear accumulator and cycle counter
// RUN   | LEN cycles: SNGs enabled, tie-break toggles, samples from k=1
// DRAIN | one cycle: SNGs off, capture last registered adder bit
// DONE  | RESULT valid, adder back in INIT, waiting for RESULT_ACK
module ss_addsub_seq #(
  parameter int N   = 6,
  parameter int LEN = 256,
  parameter int CW  = 9
) (
  input  logic          CLK,
  input  logic          INIT_N,
  input  logic          START,
  input  logic          ABORT,
  output logic          ADD_INIT,
  output logic          ADD_RCOND,
  input  logic          ADD_OUT,
  input  logic          ADD_SIGN,
  output logic          SRC_EN,
  output logic          BUSY,
  output logic [CW:0]   RESULT,
  output logic          RESULT_VALID,
  input  logic          RESULT_ACK
);

  // Elaboration-time sanity check on the parameter set.
  if (N < 1 || LEN < 2 || (64'(1) << CW) <= 64'(LEN)) begin : g_param_check
    $error("ss_addsub_seq: illegal parameters (need N>=1, LEN>=2, 2**CW > LEN)");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CW:0] PLUS_ONE  = (CW+1)'(1);
  localparam logic [CW:0] MINUS_ONE = '1;
  localparam logic [CW-1:0] LAST_K  = CW'(LEN - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW:0]   acc, acc_nxt;
  logic [CW:0]   result_nxt;
  logic [CW:0]   delta;
  logic          rcond_nxt;
  logic          init_nxt;
  logic          src_nxt;
  logic          busy_nxt;
  logic          valid_nxt;

  // Signed weight of the adder bit currently on ADD_OUT/ADD_SIGN.
  always_comb begin
    delta = '0;
    if (ADD_OUT) begin
      delta = ADD_SIGN ? MINUS_ONE : PLUS_ONE;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    result_nxt = RESULT;
    rcond_nxt  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (START) state_nxt = S_CLR;
      end
      S_CLR: begin
        acc_nxt = '0;
        cnt_nxt = '0;
        state_nxt = ABORT ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (ABORT) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          // RUN cycle 0 still shows the adder's INIT output, so skip it.
          if (cnt != '0) acc_nxt = acc + delta;
          if (cnt == LAST_K) begin
            state_nxt = S_DRAIN;
          end else begin
            rcond_nxt = ~ADD_RCOND;
          end
        end
      end
      S_DRAIN: begin
        if (ABORT) begin
          state_nxt = S_IDLE;
        end else begin
          acc_nxt    = acc + delta;
          result_nxt = acc + delta;
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        if (RESULT_ACK) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    init_nxt  = !(state_nxt == S_RUN || state_nxt == S_DRAIN);
    src_nxt   = (state_nxt == S_RUN);
    busy_nxt  = (state_nxt == S_CLR || state_nxt == S_RUN || state_nxt == S_DRAIN);
    valid_nxt = (state_nxt == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state        <= S_IDLE;
      cnt          <= '0;
      acc          <= '0;
      RESULT       <= '0;
      ADD_INIT     <= 1'b1;
      ADD_RCOND    <= 1'b0;
      SRC_EN       <= 1'b0;
      BUSY         <= 1'b0;
      RESULT_VALID <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      acc          <= acc_nxt;
      RESULT       <= result_nxt;
      ADD_INIT     <= init_nxt;
      ADD_RCOND    <= rcond_nxt;
      SRC_EN       <= src_nxt;
      BUSY         <= busy_nxt;
      RESULT_VALID <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_ss_addsub_seq.sv
// Bench for ss_addsub_seq: two instances (LEN=8 and LEN=256) driven by a
// registered-adder model; expected counts go through a scoreboard queue.
module tb_ss_addsub_seq;
  localparam int LEN_A = 8;
  localparam int CW_A  = 4;
  localparam int LEN_B = 256;
  localparam int CW_B  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start [2];
  logic abort [2];
  logic ack [2];
  logic add_out [2];
  logic add_sign [2];
  logic add_init [2];
  logic add_rcond [2];
  logic src_en [2];
  logic busy [2];
  logic valid [2];
  logic [CW_A:0] res_a;
  logic [CW_B:0] res_b;

  int n_vec = 0;
  int n_err = 0;
  int sb [$];

  bit pat_o [256];
  bit pat_s [256];
  int idx [2];
  bit prev_src [2];

  ss_addsub_seq #(.N(6), .LEN(LEN_A), .CW(CW_A)) u_dut_a (
    .CLK(clk), .INIT_N(rst_n), .START(start[0]), .ABORT(abort[0]),
    .ADD_INIT(add_init[0]), .ADD_RCOND(add_rcond[0]),
    .ADD_OUT(add_out[0]), .ADD_SIGN(add_sign[0]), .SRC_EN(src_en[0]),
    .BUSY(busy[0]), .RESULT(res_a), .RESULT_VALID(valid[0]),
    .RESULT_ACK(ack[0])
  );

  ss_addsub_seq #(.N(6), .LEN(LEN_B), .CW(CW_B)) u_dut_b (
    .CLK(clk), .INIT_N(rst_n), .START(start[1]), .ABORT(abort[1]),
    .ADD_INIT(add_init[1]), .ADD_RCOND(add_rcond[1]),
    .ADD_OUT(add_out[1]), .ADD_SIGN(add_sign[1]), .SRC_EN(src_en[1]),
    .BUSY(busy[1]), .RESULT(res_b), .RESULT_VALID(valid[1]),
    .RESULT_ACK(ack[1])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int res(input int d);
    if (d == 0) return int'($signed(res_a));
    return int'($signed(res_b));
  endfunction

  // Registered adder: the bit produced while SRC_EN was high shows up one
  // cycle later. Outside the window it emits a junk +1 that must be ignored.
  task automatic model_step(input int d);
    if (prev_src[d] && idx[d] < 256) begin
      add_out[d]  = pat_o[idx[d]];
      add_sign[d] = pat_s[idx[d]];
      idx[d]++;
    end else begin
      add_out[d]  = 1'b1;
      add_sign[d] = 1'b0;
    end
    if (src_en[d] && !prev_src[d]) idx[d] = 0;
    prev_src[d] = src_en[d];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_step(d);
  endtask

  // mode: 0 all +, 1 alternating +/-, 2 all -, 3 random
  task automatic fill(input int mode, input int len, output int expv);
    expv = 0;
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0: begin pat_o[i] = 1'b1; pat_s[i] = 1'b0; end
        1: begin pat_o[i] = 1'b1; pat_s[i] = i[0]; end
        2: begin pat_o[i] = 1'b1; pat_s[i] = 1'b1; end
        default: begin
          pat_o[i] = 1'($urandom_range(0, 1));
          pat_s[i] = 1'($urandom_range(0, 1));
        end
      endcase
      if (i < len && pat_o[i]) expv += pat_s[i] ? -1 : 1;
    end
  endtask

  task automatic run_eval(input int d, input int len, input int mode,
                          input int abort_at, input int hold);
    int expv, prev_res, t, runs, rc_err, init_err, hold_err, vrise;
    bit finished, aborted;
    fill(mode, len, expv);
    prev_res = res(d);
    if (abort_at < 0) sb.push_back(expv);
    runs = 0; rc_err = 0; init_err = 0; t = 0;
    finished = 0; aborted = 0;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check("clr_busy", busy[d], 1);
    check("clr_init", add_init[d], 1);
    while (!finished && t < len + 20) begin
      if (src_en[d]) begin
        if (add_rcond[d] !== 1'(runs % 2)) rc_err++;
        if (add_init[d] !== 1'b0) init_err++;
        if (runs == abort_at) abort[d] = 1'b1;
        runs++;
      end
      tick();
      t++;
      if (abort[d]) begin
        abort[d] = 1'b0;
        aborted = 1;
        finished = 1;
      end else if (valid[d]) begin
        finished = 1;
      end
    end
    if (abort_at >= 0) begin
      check("abort_seen", int'(aborted), 1);
      check("abort_src", src_en[d], 0);
      check("abort_busy", busy[d], 0);
      check("abort_init", add_init[d], 1);
      vrise = 0;
      for (int i = 0; i < len + 6; i++) begin
        if (valid[d]) vrise++;
        tick();
      end
      check("abort_novalid", vrise, 0);
      check("abort_result", res(d), prev_res);
    end else begin
      check("latency", t, len + 2);
      check("run_len", runs, len);
      check("rcond_seq", rc_err, 0);
      check("init_low", init_err, 0);
      if (valid[d] && sb.size() > 0) check("result", res(d), sb.pop_front());
      else begin
        check("result_timeout", int'(valid[d]), 1);
        if (sb.size() > 0) void'(sb.pop_front());
      end
      hold_err = 0;
      for (int i = 0; i < hold; i++) begin
        start[d] = (i == 3);
        tick();
        start[d] = 1'b0;
        if (!valid[d] || busy[d] || res(d) != expv) hold_err++;
      end
      check("done_hold", hold_err, 0);
      ack[d] = 1'b1;
      tick();
      ack[d] = 1'b0;
      check("ack_valid", valid[d], 0);
      check("ack_init", add_init[d], 1);
      check("ack_busy", busy[d], 0);
      tick();
      check("idle_nostart", busy[d], 0);
    end
  endtask

  task automatic back_to_back();
    int expv, rises, t1, t2, t;
    bit pv, pb;
    fill(0, LEN_A, expv);
    rises = 0; t1 = 0; t2 = 0; t = 0;
    pv = valid[0]; pb = busy[0];
    start[0] = 1'b1;
    ack[0] = 1'b1;
    while (rises < 3 && t < 100) begin
      tick();
      t++;
      if (busy[0] && !pb) sb.push_back(expv);
      if (valid[0] && !pv) begin
        rises++;
        if (rises == 1) t1 = t;
        if (rises == 2) t2 = t;
        if (sb.size() > 0) check("b2b_result", res(0), sb.pop_front());
        if (rises == 3) start[0] = 1'b0;
      end
      pv = valid[0]; pb = busy[0];
    end
    check("b2b_count", rises, 3);
    check("b2b_period", t2 - t1, LEN_A + 4);
    tick();
    ack[0] = 1'b0;
    tick();
    check("b2b_idle", busy[0], 0);
  endtask

  task automatic reset_mid_run();
    int expv;
    fill(3, LEN_A, expv);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_src", src_en[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_init", add_init[0], 1);
    check("rst_src", src_en[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_valid", valid[0], 0);
    check("rst_result", res(0), 0);
    #1 rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; ack[d] = 1'b0;
      add_out[d] = 1'b0; add_sign[d] = 1'b0;
      idx[d] = 0; prev_src[d] = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_init", add_init[0], 1);
    check("reset_rcond", add_rcond[0], 0);
    check("reset_src", src_en[0], 0);
    check("reset_busy", busy[0], 0);
    check("reset_valid", valid[0], 0);
    check("reset_result_a", res(0), 0);
    check("reset_result_b", res(1), 0);
    rst_n = 1'b1;
    tick();

    run_eval(0, LEN_A, 1, -1, 0);
    run_eval(0, LEN_A, 0, -1, 0);
    run_eval(0, LEN_A, 0, 3, 0);
    run_eval(0, LEN_A, 3, -1, 20);
    run_eval(0, LEN_A, 2, -1, 0);
    back_to_back();
    reset_mid_run();
    run_eval(0, LEN_A, 3, -1, 0);
    run_eval(0, LEN_A, 3, -1, 2);
    run_eval(1, LEN_B, 2, -1, 0);
    check("neg_raw", int'(res_b), 'h300);
    run_eval(1, LEN_B, 3, -1, 0);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
